riscv_io_bridge: RTL and testbench

RISCV_IO_BRIDGE -- requirements
Module: riscv_io_bridge

---
 rtl/riscv_io_pkg.sv | 34 +++
 rtl/io_word_asm.sv | 45 ++++
 rtl/riscv_io_bridge.sv | 173 +++++++++++++++++
 tb/tb_riscv_io_bridge.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_io_pkg.sv
// rtl/riscv_io_pkg.sv - shared state encoding, command codes and status bit indices for the io bridge
package riscv_io_pkg;

   // Bridge state encoding; values mirror the cmd codes that select them
   typedef logic [1:0] io_state_t;

   localparam io_state_t ST_IDLE = 2'd0;
   localparam io_state_t ST_LOAD = 2'd1;
   localparam io_state_t ST_RUN  = 2'd2;
   localparam io_state_t ST_READ = 2'd3;

   // Host command codes carried on uio_in[2:1]
   localparam logic [1:0] CMD_IDLE = 2'b00;
   localparam logic [1:0] CMD_LOAD = 2'b01;
   localparam logic [1:0] CMD_RUN  = 2'b10;
   localparam logic [1:0] CMD_READ = 2'b11;

   // Bit positions of the status nibble inside uio_out
   localparam int STAT_BUSY  = 7;
   localparam int STAT_READY = 6;
   localparam int STAT_RUN   = 5;
   localparam int STAT_ERR   = 4;

   // Map a host command onto the state it selects
   function automatic io_state_t cmd_to_state(input logic [1:0] cmd);
      case (cmd)
         CMD_LOAD: return ST_LOAD;
         CMD_RUN:  return ST_RUN;
         CMD_READ: return ST_READ;
         default:  return ST_IDLE;
      endcase
   endfunction

endpackage

// File: rtl/io_word_asm.sv
// rtl/io_word_asm.sv - little-endian byte-to-word assembler with one-cycle done pulse
module io_word_asm #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clear,
   input  logic            byte_valid,
   input  logic [7:0]      byte_data,
   output logic [XLEN-1:0] word,
   output logic            done,
   output logic            busy
);

   localparam int NB = XLEN / 8;
   localparam int CW = (NB > 1) ? $clog2(NB) : 1;

   logic [CW-1:0] cnt;

   // Shift bytes in from the top so the first byte lands in the LSBs; done fires after the last byte
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= '0;
         word <= '0;
         done <= 1'b0;
      end else begin
         done <= 1'b0;
         if (clear) begin
            cnt  <= '0;
            word <= '0;
         end else if (byte_valid) begin
            word <= {byte_data, word[XLEN-1:8]};
            if (cnt == CW'(NB - 1)) begin
               cnt  <= '0;
               done <= 1'b1;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end
      end
   end

   assign busy = (cnt != '0);

endmodule

// File: rtl/riscv_io_bridge.sv
// rtl/riscv_io_bridge.sv - byte-wide host bridge for loading, running and inspecting a small cpu; IO_BRIDGE_CHECKSUM_EN adds a load checksum
module riscv_io_bridge
   import riscv_io_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int IMEM_DEPTH = 64,
   parameter int NUM_DBG    = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          ena,
   input  logic [7:0]                    ui_in,
   input  logic [7:0]                    uio_in,
   output logic [7:0]                    uo_out,
   output logic [7:0]                    uio_out,
   output logic [7:0]                    uio_oe,
   output logic                          imem_we,
   output logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
   output logic [XLEN-1:0]               imem_wdata,
   input  logic [XLEN-1:0]               imem_rdata,
   output logic                          cpu_rst_n,
   input  logic [NUM_DBG*XLEN-1:0]       dbg_data
);

   localparam int AW = $clog2(IMEM_DEPTH);
   localparam int NB = XLEN / 8;
   localparam int CW = (NB > 1) ? $clog2(NB) : 1;

   io_state_t     state;
   io_state_t     next_state;
   logic          strobe_q;
   logic          stb;
   logic          state_chg;
   logic          enter_load;
   logic          enter_read;
   logic          load_byte;
   logic          read_byte;
   logic          error;
   logic [CW-1:0] rd_k;
   logic          asm_busy;
   logic [7:0]    run_byte;
   logic [7:0]    rd_byte;
   logic [7:0]    idle_byte;
   logic [7:0]    status;
   logic [3:0]    run_ch;
   logic [1:0]    run_b;
   logic          unused_ok;

   assign next_state = cmd_to_state(uio_in[2:1]);
   assign stb        = ena && uio_in[0] && !strobe_q;
   assign state_chg  = ena && (next_state != state);
   assign enter_load = state_chg && (next_state == ST_LOAD);
   assign enter_read = state_chg && (next_state == ST_READ);
   assign load_byte  = stb && !state_chg && (state == ST_LOAD) && !error;
   assign read_byte  = stb && !state_chg && (state == ST_READ);
   assign run_ch     = ui_in[5:2];
   assign run_b      = ui_in[1:0];
   assign cpu_rst_n  = (state == ST_RUN);
   assign uio_oe     = 8'hF0;
   assign unused_ok  = &{1'b0, uio_in[7:3], dbg_data};

   // Edge-detect copy of the strobe; it tracks the pin even while deselected so stale edges are dropped
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) strobe_q <= 1'b0;
      else        strobe_q <= uio_in[0];
   end

   // Any state change throws away a partially assembled word
   io_word_asm #(.XLEN(XLEN)) u_word_asm (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (state_chg),
      .byte_valid (load_byte),
      .byte_data  (ui_in),
      .word       (imem_wdata),
      .done       (imem_we),
      .busy       (asm_busy)
   );

   // State, shared load/read address, read byte index and the sticky overflow flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         imem_addr <= '0;
         rd_k      <= '0;
         error     <= 1'b0;
      end else begin
         if (state_chg) state <= next_state;
         if (enter_load || enter_read) begin
            imem_addr <= '0;
            rd_k      <= '0;
         end else if (imem_we) begin
            // The last location is written once and the address parks there
            if (imem_addr != AW'(IMEM_DEPTH - 1)) imem_addr <= imem_addr + AW'(1);
         end else if (read_byte) begin
            if (rd_k == CW'(NB - 1)) begin
               rd_k      <= '0;
               imem_addr <= imem_addr + AW'(1);
            end else begin
               rd_k <= rd_k + CW'(1);
            end
         end
         if (enter_load)
            error <= 1'b0;
         else if (imem_we && (imem_addr == AW'(IMEM_DEPTH - 1)))
            error <= 1'b1;
      end
   end

   // Debug tap byte select; unknown channels and bytes beyond the word read as zero
   always_comb begin
      run_byte = 8'h00;
      for (int i = 0; i < NUM_DBG; i++) begin
         for (int j = 0; j < NB; j++) begin
            if (j < 4 && run_ch == 4'(i) && run_b == 2'(j))
               run_byte = dbg_data[i*XLEN + j*8 +: 8];
         end
      end
   end

   // Byte k of the word the memory returned for the current address
   always_comb begin
      rd_byte = 8'h00;
      for (int j = 0; j < NB; j++) begin
         if (rd_k == CW'(j)) rd_byte = imem_rdata[j*8 +: 8];
      end
   end

`ifdef IO_BRIDGE_CHECKSUM_EN
   logic [7:0] csum;

   // Running XOR of every byte accepted into the loader
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          csum <= 8'h00;
      else if (enter_load) csum <= 8'h00;
      else if (load_byte)  csum <= csum ^ ui_in;
   end

   assign idle_byte = csum;
`else
   assign idle_byte = 8'h00;
`endif

   // Registered output byte, frozen while deselected
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         uo_out <= 8'h00;
      end else if (ena) begin
         case (state)
            ST_IDLE: uo_out <= idle_byte;
            ST_RUN:  uo_out <= run_byte;
            ST_READ: uo_out <= rd_byte;
            default: uo_out <= 8'h00;
         endcase
      end
   end

   // Status nibble in the upper half of uio_out, lower half tied low
   always_comb begin
      status             = 8'h00;
      status[STAT_BUSY]  = asm_busy;
      status[STAT_READY] = (state == ST_IDLE);
      status[STAT_RUN]   = cpu_rst_n;
      status[STAT_ERR]   = error;
   end

   // Registered so the pins read zero throughout reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) uio_out <= 8'h00;
      else        uio_out <= status;
   end

endmodule

// File: tb/tb_riscv_io_bridge.sv
// tb/tb_riscv_io_bridge.sv - randomized self-checking bench for riscv_io_bridge against a transaction-level model
module tb_riscv_io_bridge;

   localparam int XLEN  = 32;
   localparam int DEPTH = 4;
   localparam int NDBG  = 4;
   localparam int NB    = XLEN / 8;
   localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_READ = 3;

   logic                   clk = 1'b0;
   logic                   rst_n = 1'b0;
   logic                   ena = 1'b1;
   logic [7:0]             ui_in = 8'h00;
   logic [7:0]             uio_in = 8'h00;
   logic [7:0]             uo_out;
   logic [7:0]             uio_out;
   logic [7:0]             uio_oe;
   logic                   imem_we;
   logic [1:0]             imem_addr;
   logic [XLEN-1:0]        imem_wdata;
   logic [XLEN-1:0]        imem_rdata = '0;
   logic                   cpu_rst_n;
   logic [NDBG*XLEN-1:0]   dbg_data;
   logic [XLEN-1:0]        dbg_w [NDBG];

   logic [XLEN-1:0]        mem [DEPTH];
   int                     wr_a [$];
   logic [XLEN-1:0]        wr_d [$];

   int                     n_tests = 0;
   int                     n_fail = 0;

   // reference model state
   int                     m_state = M_IDLE;
   int                     m_addr = 0;
   int                     m_k = 0;
   logic                   m_err = 1'b0;
   logic [7:0]             m_csum = 8'h00;
   logic [7:0]             m_bytes [$];
   logic [XLEN-1:0]        exp_mem [DEPTH];

   always #5 clk = ~clk;

   riscv_io_bridge #(.XLEN(XLEN), .IMEM_DEPTH(DEPTH), .NUM_DBG(NDBG)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .ui_in      (ui_in),
      .uio_in     (uio_in),
      .uo_out     (uo_out),
      .uio_out    (uio_out),
      .uio_oe     (uio_oe),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .imem_rdata (imem_rdata),
      .cpu_rst_n  (cpu_rst_n),
      .dbg_data   (dbg_data)
   );

   always_comb begin
      dbg_data = '0;
      for (int i = 0; i < NDBG; i++) dbg_data[i*XLEN +: XLEN] = dbg_w[i];
   end

   // synchronous instruction memory with one cycle of read latency, plus a write log
   always @(posedge clk) begin
      if (imem_we) begin
         mem[imem_addr] <= imem_wdata;
         wr_a.push_back(int'(imem_addr));
         wr_d.push_back(imem_wdata);
      end
      imem_rdata <= mem[imem_addr];
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset;
      m_state = M_IDLE;
      m_addr  = 0;
      m_k     = 0;
      m_err   = 1'b0;
      m_csum  = 8'h00;
      m_bytes.delete();
   endtask

   task automatic check_reset(input string pfx);
      check({pfx, "_uo_out"},     uo_out,     8'h00);
      check({pfx, "_uio_out"},    uio_out,    8'h00);
      check({pfx, "_uio_oe"},     uio_oe,     8'hF0);
      check({pfx, "_imem_we"},    imem_we,    1'b0);
      check({pfx, "_imem_addr"},  imem_addr,  2'd0);
      check({pfx, "_imem_wdata"}, imem_wdata, '0);
      check({pfx, "_cpu_rst_n"},  cpu_rst_n,  1'b0);
   endtask

   task automatic check_status(input string tag);
      logic [7:0] exp;
      tick;
      exp = {m_bytes.size() != 0, m_state == M_IDLE, m_state == M_RUN, m_err, 4'h0};
      check({tag, "_status"}, uio_out, exp);
      check({tag, "_addr"}, imem_addr, m_addr);
      check({tag, "_cpu_rst_n"}, cpu_rst_n, m_state == M_RUN);
   endtask

   task automatic set_cmd(input int c);
      uio_in[2:1] = 2'(c);
      tick;
      tick;
      if (c != m_state) begin
         m_bytes.delete();
         if (c == M_LOAD || c == M_READ) begin
            m_addr = 0;
            m_k    = 0;
         end
         if (c == M_LOAD) begin
            m_err  = 1'b0;
            m_csum = 8'h00;
         end
         m_state = c;
      end
      check("no_wr_on_cmd", wr_a.size(), 0);
   endtask

   task automatic strobe(input logic [7:0] b);
      logic [XLEN-1:0] w;
      ui_in     = b;
      uio_in[0] = 1'b1;
      tick;
      uio_in[0] = 1'b0;
      tick;
      if (!ena) begin
         check("no_wr_deselected", wr_a.size(), 0);
      end else if (m_state == M_LOAD && !m_err) begin
         m_bytes.push_back(b);
         m_csum ^= b;
         if (m_bytes.size() == NB) begin
            w = '0;
            for (int i = 0; i < NB; i++) w[8*i +: 8] = m_bytes[i];
            m_bytes.delete();
            check("wr_count", wr_a.size(), 1);
            if (wr_a.size() > 0) begin
               check("wr_addr", wr_a.pop_front(), m_addr);
               check("wr_data", wr_d.pop_front(), w);
            end
            exp_mem[m_addr] = w;
            if (m_addr == DEPTH - 1) m_err = 1'b1;
            else                     m_addr++;
         end else begin
            check("no_wr_partial", wr_a.size(), 0);
         end
      end else if (m_state == M_LOAD) begin
         check("no_wr_after_error", wr_a.size(), 0);
      end else if (m_state == M_READ) begin
         m_k++;
         if (m_k == NB) begin
            m_k    = 0;
            m_addr = (m_addr + 1) % DEPTH;
         end
      end
   endtask

   task automatic load_word(input logic [XLEN-1:0] w);
      for (int i = 0; i < NB; i++) strobe(w[8*i +: 8]);
   endtask

   task automatic read_check;
      logic [XLEN-1:0] w;
      tick;
      tick;
      w = exp_mem[m_addr];
      check("read_byte", uo_out, w[8*m_k +: 8]);
      check("read_addr", imem_addr, m_addr);
   endtask

   task automatic run_check(input logic [7:0] u);
      int ch;
      int bi;
      logic [XLEN-1:0] w;
      logic [7:0] exp;
      ui_in = u;
      tick;
      tick;
      ch = int'(u[5:2]);
      bi = int'(u[1:0]);
      exp = 8'h00;
      if (ch < NDBG && bi < NB) begin
         w   = dbg_w[ch];
         exp = w[8*bi +: 8];
      end
      check("run_byte", uo_out, exp);
   endtask

   task automatic check_idle;
      tick;
`ifdef IO_BRIDGE_CHECKSUM_EN
      check("idle_uo_out", uo_out, m_csum);
`else
      check("idle_uo_out", uo_out, 8'h00);
`endif
   endtask

   initial begin
      for (int i = 0; i < NDBG; i++) dbg_w[i] = $urandom;
      for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;

      // reset state
      repeat (2) tick;
      check_reset("reset");
      rst_n = 1'b1;
      model_reset();
      tick;
      check_status("post_reset");
      check_idle();

      // first word: 13 00 00 00 -> addr 0, data 0x13, addr advances
      set_cmd(M_LOAD);
      load_word(32'h0000_0013);
      check("first_word_mem", mem[0], 32'h0000_0013);
      check_status("first_word");
      check("first_word_addr", imem_addr, 2'd1);

      // fill to the end, then one word too many
      for (int n = 1; n < 5; n++) load_word($urandom);
      check_status("overflow");
      check("overflow_err", uio_out[4], 1'b1);
      check("overflow_addr", imem_addr, 2'd3);

      // read everything back, wrapping past the last address
      set_cmd(M_READ);
      for (int n = 0; n < (DEPTH + 1) * NB; n++) begin
         read_check();
         strobe(8'($urandom));
      end
      read_check();

      // partial word discarded by a cmd change, then a clean reload at 0
      set_cmd(M_LOAD);
      check_status("reload");
      strobe(8'($urandom));
      strobe(8'($urandom));
      check_status("partial_busy");
      set_cmd(M_IDLE);
      check_status("partial_dropped");
      check_idle();
      set_cmd(M_LOAD);
      load_word($urandom);
      check_status("reload_word");

      // deselected: strobes and cmd changes are ignored
      strobe(8'($urandom));
      ena = 1'b0;
      strobe(8'($urandom));
      strobe(8'($urandom));
      uio_in[2:1] = 2'(M_IDLE);
      tick;
      check_status("deselected");
      uio_in[2:1] = 2'(M_LOAD);
      ena = 1'b1;
      tick;
      for (int i = 0; i < NB - 1; i++) strobe(8'($urandom));
      check_status("reselected");

      // run mode debug taps
      dbg_w[2] = 32'hDEAD_BEEF;
      set_cmd(M_RUN);
      run_check(8'h0B);
      check("run_deadbeef", uo_out, 8'hDE);
      run_check(8'h3C);
      check("run_bad_channel", uo_out, 8'h00);
      for (int n = 0; n < 12; n++) run_check(8'($urandom));
      check_status("run");
      set_cmd(M_IDLE);
      check_status("idle_again");

      // reset in the middle of a word
      set_cmd(M_LOAD);
      for (int i = 0; i < 3; i++) strobe(8'($urandom));
      rst_n = 1'b0;
      #1;
      check_reset("midload");
      uio_in = 8'h00;
      model_reset();
      tick;
      rst_n = 1'b1;
      repeat (3) tick;
      check("midload_no_write", wr_a.size(), 0);
      check_status("midload_release");

      // checksum of 13 00 00 00 93 00
      set_cmd(M_LOAD);
      load_word(32'h0000_0013);
      strobe(8'h93);
      strobe(8'h00);
      set_cmd(M_IDLE);
      check_idle();
`ifdef IO_BRIDGE_CHECKSUM_EN
      check("checksum_const", uo_out, 8'h80);
`else
      check("checksum_const", uo_out, 8'h00);
`endif

      check("stray_writes", wr_a.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
